// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: IF/ID latch, register file, control decode,
// sign-extend, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int          REG_COUNT = 32,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_plus_four_in,
    input  logic        in_flush,
    input  logic        in_reg_write,
    input  logic [4:0]  in_write_reg,
    input  logic [31:0] in_write_data,
    input  logic        in_ex_mem_read,
    input  logic [4:0]  in_ex_rt,
    output logic        stall_out,
    output logic [31:0] read_data1_out,
    output logic [31:0] read_data2_out,
    output logic [31:0] sign_ext_out,
    output logic [31:0] branch_target_out,
    output logic [31:0] pc_plus_four_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [5:0]  funct_out,
    output logic        reg_dst_out,
    output logic        alu_src_out,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        branch_out,
    output logic [1:0]  alu_op_out
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [REG_COUNT];

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] sign_ext;
    logic [31:0] rd1, rd2;
    logic        we;
    logic        uses_rt;
    logic        stall;
    logic        squash;

    logic        c_reg_dst, c_alu_src, c_mem_to_reg, c_reg_write;
    logic        c_mem_read, c_mem_write, c_branch;
    logic [1:0]  c_alu_op;

    logic [31:0] rd1_q, rd2_q, sext_q, bt_q, pc4_q;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic [5:0]  funct_q;
    logic        reg_dst_q, alu_src_q, mem_to_reg_q, reg_write_q;
    logic        mem_read_q, mem_write_q, branch_q;
    logic [1:0]  alu_op_q;

    assign opcode   = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign funct    = instr_q[5:0];
    assign imm      = instr_q[15:0];
    assign sign_ext = {{16{imm[15]}}, imm};

    // Only instructions that actually source rt can collide with a load's rt.
    assign uses_rt = (opcode == OP_RTYPE) | (opcode == OP_SW) | (opcode == OP_BEQ);
    assign stall   = ~rst & in_ex_mem_read & (in_ex_rt != 5'd0)
                   & ((in_ex_rt == rs) | ((in_ex_rt == rt) & uses_rt));
    assign stall_out = stall;
    assign squash    = stall | in_flush;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (in_flush) begin
            instr_d = NOP_WORD;
            pc_d    = '0;
        end else if (!stall) begin
            instr_d = instruction_in;
            pc_d    = pc_plus_four_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign we = in_reg_write & (in_write_reg != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[in_write_reg] <= in_write_data;
        end
    end

    // Write-through: a write-back landing this cycle is visible to the decode read.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs != 5'd0) begin
            rd1 = (we && in_write_reg == rs) ? in_write_data : regs_q[rs];
        end
        if (rt != 5'd0) begin
            rd2 = (we && in_write_reg == rt) ? in_write_data : regs_q[rt];
        end
    end

    always_comb begin
        c_reg_dst    = 1'b0;
        c_alu_src    = 1'b0;
        c_mem_to_reg = 1'b0;
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_branch     = 1'b0;
        c_alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                c_reg_dst   = 1'b1;
                c_reg_write = (instr_q != 32'h0);
                c_alu_op    = 2'b10;
            end
            OP_LW: begin
                c_alu_src    = 1'b1;
                c_mem_to_reg = 1'b1;
                c_reg_write  = 1'b1;
                c_mem_read   = 1'b1;
            end
            OP_SW: begin
                c_alu_src   = 1'b1;
                c_mem_write = 1'b1;
            end
            OP_BEQ: begin
                c_branch = 1'b1;
                c_alu_op = 2'b01;
            end
            OP_ADDI: begin
                c_alu_src   = 1'b1;
                c_reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_q        <= '0;
            rd2_q        <= '0;
            sext_q       <= '0;
            bt_q         <= '0;
            pc4_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            funct_q      <= '0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            alu_op_q     <= 2'b00;
        end else begin
            rd1_q   <= rd1;
            rd2_q   <= rd2;
            sext_q  <= sign_ext;
            bt_q    <= pc_q + {sign_ext[29:0], 2'b00};
            pc4_q   <= pc_q;
            rs_q    <= rs;
            rt_q    <= rt;
            rd_q    <= rd;
            funct_q <= funct;
            // Stall inserts a bubble; flush squashes the wrong-path instruction.
            reg_dst_q    <= squash ? 1'b0  : c_reg_dst;
            alu_src_q    <= squash ? 1'b0  : c_alu_src;
            mem_to_reg_q <= squash ? 1'b0  : c_mem_to_reg;
            reg_write_q  <= squash ? 1'b0  : c_reg_write;
            mem_read_q   <= squash ? 1'b0  : c_mem_read;
            mem_write_q  <= squash ? 1'b0  : c_mem_write;
            branch_q     <= squash ? 1'b0  : c_branch;
            alu_op_q     <= squash ? 2'b00 : c_alu_op;
        end
    end

    assign read_data1_out    = rd1_q;
    assign read_data2_out    = rd2_q;
    assign sign_ext_out      = sext_q;
    assign branch_target_out = bt_q;
    assign pc_plus_four_out  = pc4_q;
    assign rs_out            = rs_q;
    assign rt_out            = rt_q;
    assign rd_out            = rd_q;
    assign funct_out         = funct_q;
    assign reg_dst_out       = reg_dst_q;
    assign alu_src_out       = alu_src_q;
    assign mem_to_reg_out    = mem_to_reg_q;
    assign reg_write_out     = reg_write_q;
    assign mem_read_out      = mem_read_q;
    assign mem_write_out     = mem_write_q;
    assign branch_out        = branch_q;
    assign alu_op_out        = alu_op_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage: decode table, hazard/flush/reset
// sequences and randomized traffic against a reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_in, pc_plus_four_in;
    logic        in_flush, in_reg_write, in_ex_mem_read;
    logic [4:0]  in_write_reg, in_ex_rt;
    logic [31:0] in_write_data;
    logic        stall_out;
    logic [31:0] read_data1_out, read_data2_out, sign_ext_out, branch_target_out, pc_plus_four_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [5:0]  funct_out;
    logic        reg_dst_out, alu_src_out, mem_to_reg_out, reg_write_out;
    logic        mem_read_out, mem_write_out, branch_out;
    logic [1:0]  alu_op_out;

    id_stage dut (
        .clk(clk), .rst(rst),
        .instruction_in(instruction_in), .pc_plus_four_in(pc_plus_four_in),
        .in_flush(in_flush), .in_reg_write(in_reg_write), .in_write_reg(in_write_reg),
        .in_write_data(in_write_data), .in_ex_mem_read(in_ex_mem_read), .in_ex_rt(in_ex_rt),
        .stall_out(stall_out),
        .read_data1_out(read_data1_out), .read_data2_out(read_data2_out),
        .sign_ext_out(sign_ext_out), .branch_target_out(branch_target_out),
        .pc_plus_four_out(pc_plus_four_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .funct_out(funct_out),
        .reg_dst_out(reg_dst_out), .alu_src_out(alu_src_out), .mem_to_reg_out(mem_to_reg_out),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .branch_out(branch_out), .alu_op_out(alu_op_out)
    );

    always #5 clk = ~clk;

    logic [8:0]   ctrl_out;
    logic [189:0] outs;
    assign ctrl_out = {reg_dst_out, alu_src_out, mem_to_reg_out, reg_write_out,
                       mem_read_out, mem_write_out, branch_out, alu_op_out};
    assign outs = {read_data1_out, read_data2_out, sign_ext_out, branch_target_out,
                   pc_plus_four_out, rs_out, rt_out, rd_out, funct_out, ctrl_out};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [189:0] act, input logic [189:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_flush       = 1'b0;
        in_reg_write   = 1'b0;
        in_write_reg   = 5'd0;
        in_write_data  = 32'h0;
        in_ex_mem_read = 1'b0;
        in_ex_rt       = 5'd0;
    endtask

    // Control word from the opcode table: {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op}
    function automatic logic [8:0] ref_ctrl(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (w == 32'h0)          return 9'b1_0_0_0_0_0_0_10;
        else if (op == 6'h00)    return 9'b1_0_0_1_0_0_0_10;
        else if (op == 6'h23)    return 9'b0_1_1_1_1_0_0_00;
        else if (op == 6'h2b)    return 9'b0_1_0_0_0_1_0_00;
        else if (op == 6'h04)    return 9'b0_0_0_0_0_0_1_01;
        else if (op == 6'h08)    return 9'b0_1_0_1_0_0_0_00;
        return 9'b0;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [8:0]  ctrl;
        logic [31:0] sext;
        logic [31:0] bt;
    } vec_t;

    vec_t vecs [7];

    logic [31:0] ref_regs [32];
    logic [31:0] m_instr, m_pc;

    localparam logic [31:0] ADD_R1_R9 = {6'b000000, 5'd1, 5'd9, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] LW_WORD   = {6'b100011, 5'd4, 5'd5, 16'h0010};

    initial begin
        vecs[0] = '{{6'b000000, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20}, 32'h100, 9'b100100010, 32'h0000_5020, 32'h0001_4180};
        vecs[1] = '{{6'b100011, 5'd1, 5'd2, 16'h0004}, 32'h200, 9'b011110000, 32'h4, 32'h210};
        vecs[2] = '{{6'b101011, 5'd1, 5'd2, 16'hFFF8}, 32'h40, 9'b010001000, 32'hFFFF_FFF8, 32'h20};
        vecs[3] = '{{6'b000100, 5'd1, 5'd2, 16'hFFFF}, 32'h10, 9'b000000101, 32'hFFFF_FFFF, 32'hC};
        vecs[4] = '{{6'b001000, 5'd3, 5'd4, 16'h8000}, 32'h0, 9'b010100000, 32'hFFFF_8000, 32'hFFFE_0000};
        vecs[5] = '{{6'b000010, 5'd0, 5'd0, 16'h0001}, 32'hFFFF_FFFC, 9'b000000000, 32'h1, 32'h0};
        vecs[6] = '{32'h0, 32'h8, 9'b100000010, 32'h0, 32'h8};

        rst = 1'b1;
        set_idle();
        instruction_in  = 32'h0;
        pc_plus_four_in = 32'h0;
        #12;
        check_wide("reset_outputs", outs, '0);
        check32("reset_stall", 32'(stall_out), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            instruction_in  = vecs[i].instr;
            pc_plus_four_in = vecs[i].pc;
            tick();
            tick();
            check32($sformatf("vec%0d_ctrl", i), 32'(ctrl_out), 32'(vecs[i].ctrl));
            check32($sformatf("vec%0d_sext", i), sign_ext_out, vecs[i].sext);
            check32($sformatf("vec%0d_btarget", i), branch_target_out, vecs[i].bt);
            check32($sformatf("vec%0d_pc4", i), pc_plus_four_out, vecs[i].pc);
        end

        in_reg_write = 1'b1; in_write_reg = 5'd9; in_write_data = 32'h2;
        tick();
        set_idle();
        instruction_in = {6'b000000, 5'd0, 5'd9, 5'd1, 5'd0, 6'd0};
        tick();
        tick();
        check32("wb_read_data2", read_data2_out, 32'h2);
        check32("wb_read_data1_r0", read_data1_out, 32'h0);
        check32("wb_rd", 32'(rd_out), 32'h1);
        check32("wb_ctrl", 32'(ctrl_out), 32'(9'b100100010));

        instruction_in = {6'b000000, 5'd8, 5'd0, 5'd2, 5'd0, 6'h20};
        tick();
        in_reg_write = 1'b1; in_write_reg = 5'd8; in_write_data = 32'h1234;
        tick();
        check32("bypass_rd1", read_data1_out, 32'h1234);
        set_idle();

        instruction_in = ADD_R1_R9;
        tick();
        in_ex_mem_read = 1'b1; in_ex_rt = 5'd9;
        instruction_in = LW_WORD;
        #1;
        check32("loaduse_stall", 32'(stall_out), 32'h1);
        tick();
        check32("loaduse_bubble", 32'(ctrl_out), 32'h0);
        check32("loaduse_rt", 32'(rt_out), 32'h9);
        check32("loaduse_hold_stall", 32'(stall_out), 32'h1);
        tick();
        check32("loaduse_bubble2", 32'(ctrl_out), 32'h0);
        in_ex_rt = 5'd0;
        #1;
        check32("loaduse_rt0_nostall", 32'(stall_out), 32'h0);
        tick();
        check32("loaduse_resume_ctrl", 32'(ctrl_out), 32'(9'b100100010));
        check32("loaduse_resume_rt", 32'(rt_out), 32'h9);

        in_ex_mem_read = 1'b0;
        instruction_in = ADD_R1_R9;
        tick();
        in_ex_mem_read = 1'b1; in_ex_rt = 5'd9;
        #1;
        check32("flush_stall_active", 32'(stall_out), 32'h1);
        in_flush = 1'b1;
        tick();
        check32("flush_ctrl_zero", 32'(ctrl_out), 32'h0);
        set_idle();
        instruction_in = LW_WORD;
        #1;
        check32("flush_nop_nostall", 32'(stall_out), 32'h0);
        tick();
        check32("flush_nop_ctrl", 32'(ctrl_out), 32'(9'b100000010));
        check32("flush_nop_pc", pc_plus_four_out, 32'h0);
        check32("flush_nop_fields", 32'({rs_out, rt_out, rd_out}), 32'h0);

        in_reg_write = 1'b1; in_write_reg = 5'd5; in_write_data = 32'h7;
        instruction_in = ADD_R1_R9;
        tick();
        in_reg_write = 1'b0;
        in_ex_mem_read = 1'b1; in_ex_rt = 5'd9;
        #1;
        check32("pre_reset_stall", 32'(stall_out), 32'h1);
        rst = 1'b1;
        #2;
        check_wide("async_reset_outputs", outs, '0);
        check32("async_reset_stall", 32'(stall_out), 32'h0);
        rst = 1'b0;
        set_idle();
        instruction_in = {6'b000000, 5'd5, 5'd5, 5'd6, 5'd0, 6'h20};
        pc_plus_four_in = 32'h0;
        tick();
        tick();
        check32("after_reset_r5", read_data1_out, 32'h0);

        rst = 1'b1;
        instruction_in = 32'h0;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        m_instr = 32'h0;
        m_pc    = 32'h0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [5:0]   op;
            logic [4:0]   rs, rt;
            logic [31:0]  sx, rv1, rv2;
            logic         exp_stall;
            logic [8:0]   ctrl;
            logic [189:0] exp;
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2b;
                3: op = 6'h04;
                4: op = 6'h08;
                default: op = 6'($urandom);
            endcase
            instruction_in = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 11'($urandom)};
            if ($urandom_range(0, 9) == 0) instruction_in = 32'h0;
            pc_plus_four_in = $urandom;
            in_flush        = ($urandom_range(0, 9) == 0);
            in_reg_write    = $urandom_range(0, 1) == 1;
            in_write_reg    = 5'($urandom_range(0, 7));
            in_write_data   = $urandom;
            in_ex_mem_read  = $urandom_range(0, 2) == 0;
            in_ex_rt        = 5'($urandom_range(0, 7));
            #1;

            rs  = m_instr[25:21];
            rt  = m_instr[20:16];
            sx  = {{16{m_instr[15]}}, m_instr[15:0]};
            rv1 = (rs == 0) ? 32'h0 : ((in_reg_write && in_write_reg == rs) ? in_write_data : ref_regs[rs]);
            rv2 = (rt == 0) ? 32'h0 : ((in_reg_write && in_write_reg == rt) ? in_write_data : ref_regs[rt]);
            exp_stall = in_ex_mem_read && in_ex_rt != 0 &&
                        (in_ex_rt == rs ||
                         (in_ex_rt == rt && (m_instr[31:26] == 6'h00 || m_instr[31:26] == 6'h2b ||
                                             m_instr[31:26] == 6'h04)));
            ctrl = (exp_stall || in_flush) ? 9'h0 : ref_ctrl(m_instr);
            exp  = {rv1, rv2, sx, m_pc + (sx << 2), m_pc, rs, rt, m_instr[15:11], m_instr[5:0], ctrl};
            check32($sformatf("rand%0d_stall", cyc), 32'(stall_out), 32'(exp_stall));

            if (in_reg_write && in_write_reg != 0) ref_regs[in_write_reg] = in_write_data;
            if (in_flush) begin
                m_instr = 32'h0;
                m_pc    = 32'h0;
            end else if (!exp_stall) begin
                m_instr = instruction_in;
                m_pc    = pc_plus_four_in;
            end

            tick();
            check_wide($sformatf("rand%0d_outputs", cyc), outs, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
